// File: rtl/lut_mult_pkg.sv
// Shared types and constants for the LUT-based sequential multiplier.
// Signed operation is enabled by defining LUT_MULT_SIGNED_EN.
package lut_mult_pkg;

  typedef enum logic [1:0] {
    BUILD,
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int DIGIT_W   = 4;
  localparam int LUT_DEPTH = 16;

endpackage

// File: rtl/lut_mult_table.sv
// Multiples-of-A table: builds entry k = A*k one entry per cycle.
// LUT_MULT_SIGNED_EN makes A and the entries two's complement.
module lut_mult_table
  import lut_mult_pkg::*;
#(
  parameter int A_WIDTH = 8,
  parameter int A_INIT  = 2,
  localparam int TW = A_WIDTH + DIGIT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [A_WIDTH-1:0] a,
  input  logic [3:0]         rd_idx,
  output logic [TW-1:0]      rd_data,
`ifdef LUT_MULT_SIGNED_EN
  output logic [A_WIDTH-1:0] a_cur,
`endif
  output logic               last
);

  logic [TW-1:0]      tbl [LUT_DEPTH];
  logic [TW-1:0]      sum;
  logic [TW-1:0]      a_ext;
  logic [A_WIDTH-1:0] a_reg;
  logic [3:0]         cnt;
  logic               done;

`ifdef LUT_MULT_SIGNED_EN
  assign a_ext = TW'($signed(a_reg));
  assign a_cur = a_reg;
`else
  assign a_ext = TW'(a_reg);
`endif

  assign rd_data = tbl[rd_idx];
  assign last    = !done && (cnt == 4'd15);

  // Running sum keeps each entry one add away from the previous one.
  always_ff @(posedge clk) begin
    if (rst || start) begin
      a_reg <= rst ? A_WIDTH'(A_INIT) : a;
      sum   <= '0;
      cnt   <= '0;
      done  <= 1'b0;
    end else if (!done) begin
      tbl[cnt] <= sum;
      sum      <= sum + a_ext;
      cnt      <= cnt + 4'd1;
      if (cnt == 4'd15) done <= 1'b1;
    end
  end

endmodule

// File: rtl/lut_mult_seq.sv
// Sequential A*X multiplier, one 4-bit digit of X per cycle, MSB first.
// Define LUT_MULT_SIGNED_EN for two's complement X, A and C.
module lut_mult_seq
  import lut_mult_pkg::*;
#(
  parameter int BIT_WIDTH = 8,
  parameter int A_WIDTH   = 8,
  parameter int A_INIT    = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [BIT_WIDTH-1:0]         X,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [A_WIDTH-1:0]           A,
  input  logic                         a_valid,
  output logic                         a_ready,
  output logic [BIT_WIDTH+A_WIDTH-1:0] C,
  output logic                         out_valid,
  input  logic                         out_ready
);

  localparam int CW  = BIT_WIDTH + A_WIDTH;
  localparam int TW  = A_WIDTH + DIGIT_W;
  localparam int D   = BIT_WIDTH / DIGIT_W;
  localparam int DCW = $clog2(D + 1);

  state_t               state;
  logic [BIT_WIDTH-1:0] x_sr;
  logic [DCW-1:0]       dcnt;
  logic [CW-1:0]        acc;
  logic [CW-1:0]        acc_next;
  logic [CW-1:0]        prod;
  logic [DIGIT_W-1:0]   digit;
  logic [TW-1:0]        tbl_data;
  logic                 tbl_last;
  logic                 tbl_start;
`ifdef LUT_MULT_SIGNED_EN
  logic [A_WIDTH-1:0]   a_cur;
`endif

  assign digit     = x_sr[BIT_WIDTH-1 -: DIGIT_W];
  assign tbl_start = (state == IDLE) && a_valid;

  lut_mult_table #(
    .A_WIDTH(A_WIDTH),
    .A_INIT (A_INIT)
  ) u_table (
    .clk    (clk),
    .rst    (rst),
    .start  (tbl_start),
    .a      (A),
    .rd_idx (digit),
    .rd_data(tbl_data),
`ifdef LUT_MULT_SIGNED_EN
    .a_cur  (a_cur),
`endif
    .last   (tbl_last)
  );

  always_comb begin
`ifdef LUT_MULT_SIGNED_EN
    prod = CW'($signed(tbl_data));
    // Top digit carries weight -8: d - 16 instead of d.
    if (dcnt == '0 && digit[DIGIT_W-1])
      prod = prod - (CW'($signed(a_cur)) << DIGIT_W);
`else
    prod = CW'(tbl_data);
`endif
    acc_next = (acc << DIGIT_W) + prod;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= BUILD;
      x_sr      <= '0;
      dcnt      <= '0;
      acc       <= '0;
      C         <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
      a_ready   <= 1'b0;
    end else begin
      unique case (state)
        BUILD: begin
          if (tbl_last) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            a_ready  <= 1'b1;
          end
        end
        IDLE: begin
          if (a_valid) begin
            state    <= BUILD;
            C        <= '0;
            in_ready <= 1'b0;
            a_ready  <= 1'b0;
          end else if (in_valid) begin
            state    <= RUN;
            x_sr     <= X;
            acc      <= '0;
            dcnt     <= '0;
            in_ready <= 1'b0;
            a_ready  <= 1'b0;
          end
        end
        RUN: begin
          acc  <= acc_next;
          x_sr <= x_sr << DIGIT_W;
          dcnt <= dcnt + 1'b1;
          if (dcnt == DCW'(D - 1)) begin
            state     <= DONE;
            C         <= acc_next;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            a_ready   <= 1'b1;
          end
        end
        default: state <= BUILD;
      endcase
    end
  end

endmodule
